// File: rtl/lc3_execute.sv
// -----------------------------------------------------------------------------
// lc3_execute
//
// LC-3 execute stage, placed directly after the decode unit. Each enabled
// cycle it computes the ALU result, the address-adder result (effective or
// branch target address), the branch NZP mask, the destination register and
// the store data. All of these are registered for the memory and writeback
// stages. The register-file source indices sr1/sr2 are driven
// combinationally from the incoming IR.
//
// Optional feature (macro EXEC_BYPASS_EN):
//   defined   - operand forwarding muxes are built. bypass_alu_n forwards the
//               current aluout and has priority. Otherwise bypass_mem_n
//               forwards Mem_Bypass_Val. With neither set, the register-file
//               value is used.
//   undefined - op1 = VSR1 and op2 = VSR2. The bypass inputs remain on the
//               port list but have no effect.
//
// Ports:
//   clock            in   stage clock; all state changes on its rising edge
//   reset            in   asynchronous, active-low reset
//   enable_execute   in   registered outputs load only when this is high
//   IR               in   instruction from decode
//   npc_in           in   PC+1 from decode
//   E_Control        in   [5:4] alu_control, [3:2] pcselect1,
//                         [1] pcselect2, [0] op2select
//   Mem_Control_in   in   memory control, passed through
//   W_Control_in     in   writeback control, passed through
//   VSR1, VSR2       in   register-file values for sr1 / sr2
//   bypass_alu_1/2   in   forward aluout to operand 1 / 2
//   bypass_mem_1/2   in   forward Mem_Bypass_Val to operand 1 / 2
//   Mem_Bypass_Val   in   value forwarded from the memory stage
//   aluout           out  registered ALU result
//   pcout            out  registered address-adder result
//   M_Data           out  registered store data (operand 2 after bypass)
//   dr               out  registered destination register
//   NZP              out  registered branch condition mask
//   IR_Exec          out  registered IR
//   Mem_Control_out  out  registered copy of Mem_Control_in
//   W_Control_out    out  registered copy of W_Control_in
//   sr1, sr2         out  combinational source register indices
// -----------------------------------------------------------------------------
module lc3_execute #(
    parameter int DATA_W = 16
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              enable_execute,
    input  logic [DATA_W-1:0] IR,
    input  logic [DATA_W-1:0] npc_in,
    input  logic [5:0]        E_Control,
    input  logic              Mem_Control_in,
    input  logic [1:0]        W_Control_in,
    input  logic [DATA_W-1:0] VSR1,
    input  logic [DATA_W-1:0] VSR2,
    input  logic              bypass_alu_1,
    input  logic              bypass_alu_2,
    input  logic              bypass_mem_1,
    input  logic              bypass_mem_2,
    input  logic [DATA_W-1:0] Mem_Bypass_Val,
    output logic [DATA_W-1:0] aluout,
    output logic [DATA_W-1:0] pcout,
    output logic [DATA_W-1:0] M_Data,
    output logic [2:0]        dr,
    output logic [2:0]        NZP,
    output logic [DATA_W-1:0] IR_Exec,
    output logic              Mem_Control_out,
    output logic [1:0]        W_Control_out,
    output logic [2:0]        sr1,
    output logic [2:0]        sr2
);

    // Opcodes that the execute stage has to tell apart.
    localparam logic [3:0] OP_BR  = 4'b0000;
    localparam logic [3:0] OP_ADD = 4'b0001;
    localparam logic [3:0] OP_LD  = 4'b0010;
    localparam logic [3:0] OP_ST  = 4'b0011;
    localparam logic [3:0] OP_AND = 4'b0101;
    localparam logic [3:0] OP_LDR = 4'b0110;
    localparam logic [3:0] OP_STR = 4'b0111;
    localparam logic [3:0] OP_NOT = 4'b1001;
    localparam logic [3:0] OP_LDI = 4'b1010;
    localparam logic [3:0] OP_STI = 4'b1011;
    localparam logic [3:0] OP_JMP = 4'b1100;
    localparam logic [3:0] OP_LEA = 4'b1110;

    // Sign-extension helpers for the IR immediate and offset fields.
    function automatic logic [DATA_W-1:0] sext5(input logic [4:0] v);
        return {{(DATA_W-5){v[4]}}, v};
    endfunction

    function automatic logic [DATA_W-1:0] sext6(input logic [5:0] v);
        return {{(DATA_W-6){v[5]}}, v};
    endfunction

    function automatic logic [DATA_W-1:0] sext9(input logic [8:0] v);
        return {{(DATA_W-9){v[8]}}, v};
    endfunction

    function automatic logic [DATA_W-1:0] sext11(input logic [10:0] v);
        return {{(DATA_W-11){v[10]}}, v};
    endfunction

    // Decoded fields of the control word.
    logic [3:0]        opcode_s;
    logic [1:0]        alu_control_s;
    logic [1:0]        pcselect1_s;
    logic              pcselect2_s;
    logic              op2select_s;

    // Datapath intermediates.
    logic [DATA_W-1:0] op1_s;
    logic [DATA_W-1:0] op2_s;
    logic [DATA_W-1:0] alu_b_s;
    logic [DATA_W-1:0] alu_res_s;
    logic [DATA_W-1:0] addr1_s;
    logic [DATA_W-1:0] addr2_s;
    logic [DATA_W-1:0] pc_res_s;
    logic [2:0]        nzp_s;
    logic [2:0]        dr_s;
    logic [2:0]        sr2_s;

    // Pipeline registers.
    logic [DATA_W-1:0] aluout_r;
    logic [DATA_W-1:0] pcout_r;
    logic [DATA_W-1:0] m_data_r;
    logic [2:0]        dr_r;
    logic [2:0]        nzp_r;
    logic [DATA_W-1:0] ir_exec_r;
    logic              mem_control_r;
    logic [1:0]        w_control_r;

    assign opcode_s      = IR[15:12];
    assign alu_control_s = E_Control[5:4];
    assign pcselect1_s   = E_Control[3:2];
    assign pcselect2_s   = E_Control[1];
    assign op2select_s   = E_Control[0];

    assign sr1 = IR[8:6];
    assign sr2 = sr2_s;

    // Source 2 index: register-form ALU ops use IR[2:0]; stores read the
    // data register from IR[11:9].
    always_comb begin
        sr2_s = 3'b000;
        case (opcode_s)
            OP_ADD, OP_AND, OP_NOT: sr2_s = IR[2:0];
            OP_ST,  OP_STR, OP_STI: sr2_s = IR[11:9];
            default:                sr2_s = 3'b000;
        endcase
    end

`ifdef EXEC_BYPASS_EN
    // Operand forwarding. When both paths are requested the ALU path wins,
    // because it carries the younger result.
    always_comb begin
        op1_s = VSR1;
        op2_s = VSR2;
        if (bypass_alu_1) begin
            op1_s = aluout_r;
        end else if (bypass_mem_1) begin
            op1_s = Mem_Bypass_Val;
        end else begin
            op1_s = VSR1;
        end
        if (bypass_alu_2) begin
            op2_s = aluout_r;
        end else if (bypass_mem_2) begin
            op2_s = Mem_Bypass_Val;
        end else begin
            op2_s = VSR2;
        end
    end
`else
    // No forwarding: operands come straight from the register file.
    assign op1_s = VSR1;
    assign op2_s = VSR2;

    // The bypass ports stay on the interface but have no effect.
    logic unused_bypass_s;
    assign unused_bypass_s = ^{bypass_alu_1, bypass_alu_2, bypass_mem_1,
                               bypass_mem_2, Mem_Bypass_Val};
`endif

    // ALU: operand B is either op2 or the sign-extended imm5 field.
    always_comb begin
        alu_b_s   = op2select_s ? op2_s : sext5(IR[4:0]);
        alu_res_s = {DATA_W{1'b0}};
        case (alu_control_s)
            2'b00:   alu_res_s = op1_s + alu_b_s;
            2'b01:   alu_res_s = op1_s & alu_b_s;
            2'b10:   alu_res_s = ~op1_s;
            2'b11:   alu_res_s = {DATA_W{1'b0}};
            default: alu_res_s = {DATA_W{1'b0}};
        endcase
    end

    // Address adder: an offset field (or zero) added to the PC or to a base
    // register.
    always_comb begin
        addr1_s = {DATA_W{1'b0}};
        case (pcselect1_s)
            2'b00:   addr1_s = sext11(IR[10:0]);
            2'b01:   addr1_s = sext9(IR[8:0]);
            2'b10:   addr1_s = sext6(IR[5:0]);
            2'b11:   addr1_s = {DATA_W{1'b0}};
            default: addr1_s = {DATA_W{1'b0}};
        endcase
        addr2_s  = pcselect2_s ? npc_in : op1_s;
        pc_res_s = addr1_s + addr2_s;
    end

    // Branch mask: BR uses its nzp field. JMP is an unconditional branch,
    // so its mask is all ones.
    always_comb begin
        nzp_s = 3'b000;
        case (opcode_s)
            OP_BR:   nzp_s = IR[11:9];
            OP_JMP:  nzp_s = 3'b111;
            default: nzp_s = 3'b000;
        endcase
    end

    // Destination register, only for instructions that write the register file.
    always_comb begin
        dr_s = 3'b000;
        case (opcode_s)
            OP_ADD, OP_AND, OP_NOT, OP_LD,
            OP_LDR, OP_LDI, OP_LEA: dr_s = IR[11:9];
            default:                dr_s = 3'b000;
        endcase
    end

    // Execute-to-memory pipeline registers. They load only on enabled cycles.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            aluout_r      <= {DATA_W{1'b0}};
            pcout_r       <= {DATA_W{1'b0}};
            m_data_r      <= {DATA_W{1'b0}};
            dr_r          <= 3'b000;
            nzp_r         <= 3'b000;
            ir_exec_r     <= {DATA_W{1'b0}};
            mem_control_r <= 1'b0;
            w_control_r   <= 2'b00;
        end else if (enable_execute) begin
            aluout_r      <= alu_res_s;
            pcout_r       <= pc_res_s;
            m_data_r      <= op2_s;
            dr_r          <= dr_s;
            nzp_r         <= nzp_s;
            ir_exec_r     <= IR;
            mem_control_r <= Mem_Control_in;
            w_control_r   <= W_Control_in;
        end else begin
            aluout_r      <= aluout_r;
            pcout_r       <= pcout_r;
            m_data_r      <= m_data_r;
            dr_r          <= dr_r;
            nzp_r         <= nzp_r;
            ir_exec_r     <= ir_exec_r;
            mem_control_r <= mem_control_r;
            w_control_r   <= w_control_r;
        end
    end

    assign aluout          = aluout_r;
    assign pcout           = pcout_r;
    assign M_Data          = m_data_r;
    assign dr              = dr_r;
    assign NZP             = nzp_r;
    assign IR_Exec         = ir_exec_r;
    assign Mem_Control_out = mem_control_r;
    assign W_Control_out   = w_control_r;

endmodule

// File: tb/tb_lc3_execute.sv
// -----------------------------------------------------------------------------
// tb_lc3_execute
//
// Directed self-checking bench for lc3_execute. Every expected value is
// computed by hand from the instruction encoding. Expected values for the
// forwarding cases follow EXEC_BYPASS_EN, so the bench is built with the
// same defines as the design.
// -----------------------------------------------------------------------------
module tb_lc3_execute;

    logic        clock;
    logic        reset;
    logic        enable_execute;
    logic [15:0] IR;
    logic [15:0] npc_in;
    logic [5:0]  E_Control;
    logic        Mem_Control_in;
    logic [1:0]  W_Control_in;
    logic [15:0] VSR1;
    logic [15:0] VSR2;
    logic        bypass_alu_1;
    logic        bypass_alu_2;
    logic        bypass_mem_1;
    logic        bypass_mem_2;
    logic [15:0] Mem_Bypass_Val;
    logic [15:0] aluout;
    logic [15:0] pcout;
    logic [15:0] M_Data;
    logic [2:0]  dr;
    logic [2:0]  NZP;
    logic [15:0] IR_Exec;
    logic        Mem_Control_out;
    logic [1:0]  W_Control_out;
    logic [2:0]  sr1;
    logic [2:0]  sr2;

    int check_count = 0;
    int error_count = 0;

    lc3_execute #(.DATA_W(16)) dut (
        .clock          (clock),
        .reset          (reset),
        .enable_execute (enable_execute),
        .IR             (IR),
        .npc_in         (npc_in),
        .E_Control      (E_Control),
        .Mem_Control_in (Mem_Control_in),
        .W_Control_in   (W_Control_in),
        .VSR1           (VSR1),
        .VSR2           (VSR2),
        .bypass_alu_1   (bypass_alu_1),
        .bypass_alu_2   (bypass_alu_2),
        .bypass_mem_1   (bypass_mem_1),
        .bypass_mem_2   (bypass_mem_2),
        .Mem_Bypass_Val (Mem_Bypass_Val),
        .aluout         (aluout),
        .pcout          (pcout),
        .M_Data         (M_Data),
        .dr             (dr),
        .NZP            (NZP),
        .IR_Exec        (IR_Exec),
        .Mem_Control_out(Mem_Control_out),
        .W_Control_out  (W_Control_out),
        .sr1            (sr1),
        .sr2            (sr2)
    );

    // 10-time-unit clock with rising edges at 5, 15, 25, ...
    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Compare one observed value with its expected value. Count the
    // comparison and report any difference.
    task automatic check_val(input string tag, input logic [15:0] obs,
                             input logic [15:0] exp);
        check_count++;
        if (obs !== exp) begin
            error_count++;
            $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Drive the per-instruction inputs.
    task automatic drive(input logic [15:0] ir, input logic [5:0] ectl,
                         input logic [15:0] npc, input logic [15:0] v1,
                         input logic [15:0] v2);
        IR        = ir;
        E_Control = ectl;
        npc_in    = npc;
        VSR1      = v1;
        VSR2      = v2;
    endtask

    // Wait for the next rising edge, then step 1 unit past it so outputs are
    // sampled away from the edge.
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    logic [15:0] exp_byp;
    logic [15:0] exp_mdata;

    initial begin
        reset          = 1'b0;
        enable_execute = 1'b0;
        Mem_Control_in = 1'b0;
        W_Control_in   = 2'b00;
        bypass_alu_1   = 1'b0;
        bypass_alu_2   = 1'b0;
        bypass_mem_1   = 1'b0;
        bypass_mem_2   = 1'b0;
        Mem_Bypass_Val = 16'h0000;
        drive(16'h0000, 6'b000000, 16'h0000, 16'h0000, 16'h0000);

        // Reset state.
        #2;
        check_val("rst_aluout", aluout, 16'h0000);
        check_val("rst_pcout",  pcout,  16'h0000);
        check_val("rst_ir",     IR_Exec, 16'h0000);
        check_val("rst_nzp",    {13'd0, NZP}, 16'h0000);
        tick();
        reset = 1'b1;
        enable_execute = 1'b1;

        // ADD R1, R2, R3: 5 + 7.
        drive(16'h1283, 6'b000001, 16'h3000, 16'd5, 16'd7);
        #1;
        check_val("add_sr1", {13'd0, sr1}, 16'd2);
        check_val("add_sr2", {13'd0, sr2}, 16'd3);
        tick();
        check_val("add_alu", aluout, 16'd12);
        check_val("add_dr",  {13'd0, dr}, 16'd1);
        check_val("add_ir",  IR_Exec, 16'h1283);

        // ADD R0, R1, #1 with R1 = FFFF wraps to 0.
        drive(16'h1061, 6'b000000, 16'h3000, 16'hFFFF, 16'h0000);
        tick();
        check_val("addi_wrap", aluout, 16'h0000);
        check_val("addi_dr",   {13'd0, dr}, 16'd0);

        // AND R3, R2, #-1 gives R2 unchanged.
        drive(16'h56BF, 6'b010000, 16'h3000, 16'hA5C3, 16'h0000);
        tick();
        check_val("and_alu", aluout, 16'hA5C3);
        check_val("and_dr",  {13'd0, dr}, 16'd3);

        // NOT R4, R1.
        drive(16'h987F, 6'b100000, 16'h3000, 16'h00F0, 16'h0000);
        tick();
        check_val("not_alu", aluout, 16'hFF0F);
        check_val("not_dr",  {13'd0, dr}, 16'd4);

        // BRnp with offset9 = -2 from npc 3001.
        drive(16'h0BFE, 6'b110110, 16'h3001, 16'h1111, 16'h2222);
        tick();
        check_val("br_pc",  pcout, 16'h2FFF);
        check_val("br_nzp", {13'd0, NZP}, 16'h0005);
        check_val("br_dr",  {13'd0, dr}, 16'd0);
        check_val("br_alu", aluout, 16'h0000);

        // JMP R5 -> pcout = R5 and an unconditional mask.
        drive(16'hC140, 6'b111100, 16'h3005, 16'h4000, 16'h0000);
        tick();
        check_val("jmp_pc",  pcout, 16'h4000);
        check_val("jmp_nzp", {13'd0, NZP}, 16'h0007);

        // LDR R6, R2, #-3: base + sext(offset6).
        drive(16'h6CBD, 6'b111000, 16'h3006, 16'h3010, 16'h0000);
        tick();
        check_val("ldr_pc",  pcout, 16'h300D);
        check_val("ldr_dr",  {13'd0, dr}, 16'd6);
        check_val("ldr_nzp", {13'd0, NZP}, 16'h0000);

        // JSR with offset11 = -1 from npc 3000.
        drive(16'h4FFF, 6'b110010, 16'h3000, 16'h0000, 16'h0000);
        tick();
        check_val("jsr_pc", pcout, 16'h2FFF);
        check_val("jsr_dr", {13'd0, dr}, 16'd0);

        // STR R7, R1, #0 with the control passthroughs set.
        drive(16'h7E40, 6'b111000, 16'h3008, 16'h5000, 16'hBEEF);
        Mem_Control_in = 1'b1;
        W_Control_in   = 2'b10;
        #1;
        check_val("str_sr1", {13'd0, sr1}, 16'd1);
        check_val("str_sr2", {13'd0, sr2}, 16'd7);
        tick();
        check_val("str_pc",    pcout,  16'h5000);
        check_val("str_mdata", M_Data, 16'hBEEF);
        check_val("str_dr",    {13'd0, dr}, 16'd0);
        check_val("str_memc",  {15'd0, Mem_Control_out}, 16'd1);
        check_val("str_wc",    {14'd0, W_Control_out}, 16'd2);

        // Non-ALU, non-store opcode: sr2 is 0.
        drive(16'hC1C7, 6'b111100, 16'h3009, 16'h0000, 16'h0000);
        #1;
        check_val("jmp_sr2", {13'd0, sr2}, 16'd0);

        // Hold: enable low for 3 cycles while IR and operands change.
        enable_execute = 1'b0;
        Mem_Control_in = 1'b0;
        W_Control_in   = 2'b01;
        for (int i = 0; i < 3; i++) begin
            drive(16'h1000 + 16'(i), 6'b000001, 16'h4000, 16'h0101, 16'h0202);
            tick();
        end
        check_val("hold_alu",  aluout,  16'h0000);
        check_val("hold_pc",   pcout,   16'h5000);
        check_val("hold_ir",   IR_Exec, 16'h7E40);
        check_val("hold_memc", {15'd0, Mem_Control_out}, 16'd1);
        enable_execute = 1'b1;

        // Build aluout = 10 to use in the forwarding tests.
        drive(16'h1283, 6'b000001, 16'h3000, 16'd3, 16'd7);
        tick();
        check_val("pre_alu", aluout, 16'd10);

        // Both bypasses on operand 1: the ALU path wins.
        bypass_alu_1   = 1'b1;
        bypass_mem_1   = 1'b1;
        Mem_Bypass_Val = 16'd20;
        drive(16'h1283, 6'b000001, 16'h3000, 16'd99, 16'd1);
`ifdef EXEC_BYPASS_EN
        exp_byp = 16'd11;
`else
        exp_byp = 16'd100;
`endif
        tick();
        check_val("byp_prio", aluout, exp_byp);

        // Memory bypass on operand 2; it also feeds the store data.
        bypass_alu_1 = 1'b0;
        bypass_mem_1 = 1'b0;
        bypass_mem_2 = 1'b1;
        drive(16'h1283, 6'b000001, 16'h3000, 16'd5, 16'd9);
`ifdef EXEC_BYPASS_EN
        exp_byp   = 16'd25;
        exp_mdata = 16'd20;
`else
        exp_byp   = 16'd14;
        exp_mdata = 16'd9;
`endif
        tick();
        check_val("byp_mem2",  aluout, exp_byp);
        check_val("byp_mdata", M_Data, exp_mdata);

        // ALU bypass on operand 2 beats the memory bypass.
        bypass_alu_2 = 1'b1;
        drive(16'h1283, 6'b000001, 16'h3000, 16'd1, 16'd9);
`ifdef EXEC_BYPASS_EN
        exp_byp = 16'd26;
`else
        exp_byp = 16'd10;
`endif
        tick();
        check_val("byp_alu2", aluout, exp_byp);
        bypass_alu_2 = 1'b0;
        bypass_mem_2 = 1'b0;

        // Mid-run reset: load 1234, then clear asynchronously between edges.
        drive(16'h1283, 6'b000001, 16'h3000, 16'h1000, 16'h0234);
        Mem_Control_in = 1'b1;
        tick();
        check_val("pre_rst_alu", aluout, 16'h1234);
        reset = 1'b0;
        #1;
        check_val("mid_rst_alu",  aluout,  16'h0000);
        check_val("mid_rst_pc",   pcout,   16'h0000);
        check_val("mid_rst_md",   M_Data,  16'h0000);
        check_val("mid_rst_ir",   IR_Exec, 16'h0000);
        check_val("mid_rst_dr",   {13'd0, dr}, 16'd0);
        check_val("mid_rst_memc", {15'd0, Mem_Control_out}, 16'd0);
        check_val("mid_rst_wc",   {14'd0, W_Control_out}, 16'd0);
        #1;
        reset = 1'b1;

        // The first enabled edge after reset release loads normally.
        drive(16'h1283, 6'b000001, 16'h3000, 16'd5, 16'd7);
        tick();
        check_val("post_rst_alu", aluout,  16'd12);
        check_val("post_rst_ir",  IR_Exec, 16'h1283);

        $display("CHECKS %0d ERRORS %0d", check_count, error_count);
        $finish;
    end

endmodule
